// File: rtl/square_acc.sv
// square_acc: pipelined squarer with an optional sum-of-squares accumulator.
// Each sample carries a mode tag: mode 0 emits its own square, mode 1 adds it
// to a running sum, and the sum is emitted after every ACC_LEN mode-1 samples.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   enable          - global clock enable (0 freezes all state)
//   in_valid/in_ready/in_data/mode - sample handshake, data and tag
//   out_valid/out_ready/out_data   - result handshake and data
//   acc_drop        - one-cycle pulse when a partial sum is discarded
module square_acc #(
  parameter int unsigned DATA_W  = 16,
  parameter bit          SIGNED  = 1'b1,
  parameter int unsigned PIPE    = 2,
  parameter int unsigned ACC_LEN = 16,
  localparam int unsigned SQ_W   = SIGNED ? 2 * DATA_W - 1 : 2 * DATA_W,
  localparam int unsigned OUT_W  = SQ_W + $clog2(ACC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              acc_drop
);

  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(ACC_LEN);

  typedef enum logic {IDLE, RUN} state_t;

  logic             advance;
  logic [PW-1:0]    prod;
  logic [SQ_W-1:0]  sq_in;
  logic             h_valid;
  logic             h_mode;
  logic [SQ_W-1:0]  h_sq;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] sum;
  logic             out_valid_d;
  logic [OUT_W-1:0] out_data_d;
  logic             acc_drop_d;

  // Whole design moves as one: stall when the output is full and not taken.
  assign advance  = enable && (!out_valid || out_ready);
  assign in_ready = advance;

  // Exact square; a signed square is non-negative and fits in 2*DATA_W-1 bits.
  if (SIGNED) begin : g_sq_signed
    logic signed [PW-1:0] ext;
    assign ext  = PW'($signed(in_data));
    assign prod = ext * ext;
  end else begin : g_sq_unsigned
    assign prod = PW'(in_data) * PW'(in_data);
  end
  assign sq_in = SQ_W'(prod);

  // PIPE-1 multiplier stages; the output register is the final stage.
  if (PIPE == 1) begin : g_nopipe
    assign h_valid = in_valid;
    assign h_mode  = mode;
    assign h_sq    = sq_in;
  end else begin : g_pipe
    localparam int unsigned NS = PIPE - 1;
    logic            st_v  [NS];
    logic            st_m  [NS];
    logic [SQ_W-1:0] st_sq [NS];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(NS); i++) st_v[i] <= 1'b0;
      end else if (advance) begin
        st_v[0]  <= in_valid;
        st_m[0]  <= mode;
        st_sq[0] <= sq_in;
        for (int i = 1; i < int'(NS); i++) begin
          st_v[i]  <= st_v[i-1];
          st_m[i]  <= st_m[i-1];
          st_sq[i] <= st_sq[i-1];
        end
      end
    end

    assign h_valid = st_v[NS-1];
    assign h_mode  = st_m[NS-1];
    assign h_sq    = st_sq[NS-1];
  end

  // Output stage: square pass-through and accumulator FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    acc_drop_d  = 1'b0;
    sum         = acc_q + OUT_W'(h_sq);
    if (advance) begin
      // On advance any held result is being accepted, so it clears unless reloaded.
      out_valid_d = 1'b0;
      if (h_valid) begin
        if (!h_mode) begin
          out_valid_d = 1'b1;
          out_data_d  = OUT_W'(h_sq);
          acc_drop_d  = (state_q == RUN);
          state_d     = IDLE;
          cnt_d       = '0;
          acc_d       = '0;
        end else if (state_q == IDLE) begin
          acc_d   = OUT_W'(h_sq);
          cnt_d   = CNT_W'(1);
          state_d = RUN;
        end else if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
          out_valid_d = 1'b1;
          out_data_d  = sum;
          state_d     = IDLE;
          cnt_d       = '0;
          acc_d       = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc_drop  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      acc_drop  <= acc_drop_d;
    end
  end

endmodule

// File: tb/tb_square_acc.sv
// Testbench for square_acc: directed vectors, scoreboard queue of hand-computed
// results, and an independent monitor popping on every accepted output beat.
module tb_square_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;
  logic        acc_drop;

  logic        mode_u;
  logic        in_valid_u;
  logic        in_ready_u;
  logic [15:0] in_data_u;
  logic        out_valid_u;
  logic        out_ready_u;
  logic [33:0] out_data_u;
  logic        acc_drop_u;

  int          n_total = 0;
  int          n_pass  = 0;
  int          drops   = 0;
  logic [63:0] sb[$];
  logic        stall_prev = 1'b0;
  logic [32:0] stall_data = '0;

  always #5 clk = ~clk;

  square_acc #(.DATA_W(16), .SIGNED(1'b1), .PIPE(2), .ACC_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc_drop(acc_drop)
  );

  square_acc #(.DATA_W(16), .SIGNED(1'b0), .PIPE(2), .ACC_LEN(4)) u_dut_u (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode_u),
    .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data_u),
    .out_valid(out_valid_u), .out_ready(out_ready_u), .out_data(out_data_u),
    .acc_drop(acc_drop_u)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Present one sample (called just after a rising edge); returns just after
  // the edge that accepted it.
  task automatic send(input logic m, input logic [15:0] d);
    int tries = 0;
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      tries++;
      if (tries > 100) begin
        n_total++;
        $display("FAIL send_timeout: got in_ready 0 want 1 (data %0d)", d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted beat against the scoreboard head,
  // check data is held during stalls, and count acc_drop pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev)
        chk("stall_hold", {31'd0, out_valid, out_data}, {31'd0, 1'b1, stall_data});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got %0d want none", out_data);
        end else begin
          chk("out_data", 64'(out_data), sb.pop_front());
        end
      end
      if (acc_drop) drops++;
    end
    stall_prev = !rst && out_valid && !out_ready;
    stall_data = out_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    mode_u = 1'b0; in_valid_u = 1'b0; in_data_u = '0; out_ready_u = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and first-cycle readiness.
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_acc_drop", 64'(acc_drop), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Most-negative input, with latency check.
    sb.push_back(64'd1073741824);
    send(1'b0, 16'h8000);
    @(negedge clk);
    chk("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_pipe", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    sb.push_back(64'd9);
    sb.push_back(64'd25);
    send(1'b0, 16'd3);
    send(1'b0, 16'hFFFB);
    drain();

    // One group of four: 1+4+9+16.
    sb.push_back(64'd30);
    send(1'b1, 16'd1);
    send(1'b1, 16'd2);
    send(1'b1, 16'd3);
    send(1'b1, 16'd4);
    drain();

    // Partial group interrupted by a square, then a fresh group.
    sb.push_back(64'd49);
    sb.push_back(64'd4);
    send(1'b1, 16'd5);
    send(1'b1, 16'd6);
    send(1'b0, 16'd7);
    for (int i = 0; i < 4; i++) send(1'b1, 16'd1);
    drain();

    // Downstream stall while input keeps streaming.
    sb.push_back(64'd100);
    sb.push_back(64'd121);
    sb.push_back(64'd144);
    sb.push_back(64'd169);
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 16'd10);
        send(1'b0, 16'd11);
        send(1'b0, 16'd12);
        send(1'b0, 16'd13);
      end
      begin
        int k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!out_valid && k < 20);
        chk("stall_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Global enable low freezes a sample in flight.
    sb.push_back(64'd400);
    send(1'b0, 16'd20);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("en_in_ready", 64'(in_ready), 64'd0);
      chk("en_frozen", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1 enable = 1'b1;
    drain();

    // Reset with a partial sum in flight, then a clean group.
    send(1'b1, 16'd9);
    send(1'b1, 16'd9);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_data", 64'(out_data), 64'd0);
    chk("rst2_acc_drop", 64'(acc_drop), 64'd0);
    @(posedge clk);
    #1;
    sb.push_back(64'd16);
    for (int i = 0; i < 4; i++) send(1'b1, 16'd2);
    drain();

    // Unsigned instance: largest input.
    in_valid_u = 1'b1; mode_u = 1'b0; in_data_u = 16'hFFFF;
    @(negedge clk);
    chk("u_in_ready", 64'(in_ready_u), 64'd1);
    @(posedge clk);
    #1 in_valid_u = 1'b0;
    @(negedge clk);
    chk("u_lat_early", 64'(out_valid_u), 64'd0);
    @(negedge clk);
    chk("u_out_valid", 64'(out_valid_u), 64'd1);
    chk("u_out_data", 64'(out_data_u), 64'd4294836225);

    chk("acc_drop_pulses", 64'(drops), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/square_acc.md
SQUARE_ACC -- requirements
Module: square_acc

Interface
REQ-001 Parameter DATA_W, 16: input sample width, 2..32.
REQ-002 Parameter SIGNED, 1: 1 = in_data two's complement, 0 = unsigned.
REQ-003 Parameter PIPE, 2: total latency in cycles, 1..4; PIPE-1 multiplier register stages plus one output register.
REQ-004 Parameter ACC_LEN, 16: squares per accumulated result, 2..1024.
REQ-005 Derived: SQ_W = 2*DATA_W-1 if SIGNED else 2*DATA_W; OUT_W = SQ_W + clog2(ACC_LEN).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  global clock enable; 0 freezes all state.
REQ-009 mode  input  1  per-sample tag: 0 = square, 1 = accumulate.
REQ-010 in_valid  input  1  in_data/mode valid.
REQ-011 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-012 in_data  input  DATA_W  sample.
REQ-013 out_valid  output  1  out_data valid; held until accepted.
REQ-014 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-015 out_data  output  OUT_W  square (zero-extended) or sum of squares.
REQ-016 acc_drop  output  1  one-cycle pulse: partial accumulation discarded.

Function
REQ-017 advance = enable && (!out_valid || out_ready); in_ready SHALL equal advance combinationally.
REQ-018 On advance, every pipeline stage SHALL shift by one, carrying valid, mode and data; bubbles (valid=0) SHALL shift likewise; without advance no stage, counter or accumulator SHALL change.
REQ-019 Square SHALL be exact: in_data*in_data, signed or unsigned per SIGNED, no truncation or saturation within SQ_W.
REQ-020 Mode-0 sample reaching the output register with cnt==0 SHALL load out_data with the zero-extended square and set out_valid; latency = PIPE cycles from acceptance with no stall.
REQ-021 Accumulator FSM states: IDLE (cnt==0, acc==0) and RUN (1<=cnt<=ACC_LEN-1).
REQ-022 IDLE + mode-1 sample: acc <= square, cnt <= 1, go RUN; out_valid unchanged by this sample.
REQ-023 RUN + mode-1 sample, cnt<ACC_LEN-1: acc <= acc+square, cnt <= cnt+1.
REQ-024 RUN + mode-1 sample, cnt==ACC_LEN-1: out_data <= acc+square, out_valid <= 1, acc <= 0, cnt <= 0, go IDLE; result emitted PIPE cycles after the ACC_LEN-th acceptance.
REQ-025 RUN + mode-0 sample: acc and cnt cleared, go IDLE, acc_drop pulses one cycle, and the sample's square is output per REQ-020.
REQ-026 Sum SHALL be exact in OUT_W; worst case ACC_LEN*max_square never overflows.
REQ-027 out_valid SHALL clear on accept unless a new result loads in the same cycle, in which case it stays 1 with new out_data.
REQ-028 out_data SHALL remain stable while out_valid && !out_ready.
REQ-029 enable=0 SHALL force in_ready=0 and hold out_valid/out_data, cnt, acc, pipeline.

Reset
REQ-030 rst=1 at a clock edge SHALL clear all pipeline valids, cnt, acc, out_data (0), out_valid (0), acc_drop (0), regardless of enable or handshake.
REQ-031 rst SHALL take priority over all other inputs; samples in flight SHALL be lost, none emitted after reset.
REQ-032 First sample SHALL be acceptable the cycle after rst deasserts (in_ready=1 if enable=1).

Verification (DATA_W=16, SIGNED=1, PIPE=2, ACC_LEN=4 unless stated)
REQ-033 mode=0, in_data=-32768, out_ready=1 -> out_valid 2 cycles later, out_data=1073741824.
REQ-034 SIGNED=0, in_data=65535, mode=0 -> out_data=4294836225 after 2 cycles.
REQ-035 mode=1, back-to-back 1,2,3,4 -> one out_valid beat, out_data=30, 2 cycles after sample 4; no output for samples 1-3.
REQ-036 out_ready=0 for 5 cycles with out_valid=1, in_valid=1 streaming -> in_ready=0, out_data held, no sample lost or duplicated once out_ready=1.
REQ-037 mode=1 samples 5,6 then mode=0 sample 7 -> acc_drop one pulse, out_data=49, next mode-1 group of 1,1,1,1 yields 4.
REQ-038 rst=1 after two mode-1 samples in flight -> all outputs 0 next cycle; then 2,2,2,2 mode=1 -> out_data=16.
